// File: rtl/ysyx_25020037_rxbar_pkg.sv
// Shared definitions for the LSU read crossbar: address map, FSM states and
// AXI response codes.
package ysyx_25020037_rxbar_pkg;

   localparam logic [31:0] CLINT_BASE  = 32'h0200_0000;
   localparam logic [31:0] CLINT_SIZE  = 32'h0001_0000;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  id;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_req_t;

endpackage

// File: rtl/ysyx_25020037_rxbar_dec.sv
// Address decode: selects the CLINT window, everything else goes to the SoC.
module ysyx_25020037_rxbar_dec
   import ysyx_25020037_rxbar_pkg::*;
(
   input  logic [31:0] addr,
   output logic        sel_clint
);

   // Unsigned wrap-around subtract keeps the window check a single compare.
   logic [31:0] offset;

   assign offset    = addr - CLINT_BASE;
   assign sel_clint = (offset < CLINT_SIZE);

endmodule

// File: rtl/ysyx_25020037_rxbar.sv
// AXI4 read crossbar: one LSU master to CLINT / SoC slaves, one transaction
// in flight; AR is registered (1 cycle), R is a combinational pass-through.
module ysyx_25020037_rxbar
   import ysyx_25020037_rxbar_pkg::*;
(
   input  logic        clk,
   input  logic        rst,

   input  logic        in_arvalid,
   output logic        in_arready,
   input  logic [31:0] in_araddr,
   input  logic [3:0]  in_arid,
   input  logic [7:0]  in_arlen,
   input  logic [2:0]  in_arsize,
   input  logic [1:0]  in_arburst,
   output logic        in_rvalid,
   input  logic        in_rready,
   output logic [31:0] in_rdata,
   output logic [1:0]  in_rresp,
   output logic        in_rlast,
   output logic [3:0]  in_rid,

   output logic        clint_arvalid,
   input  logic        clint_arready,
   output logic [31:0] clint_araddr,
   output logic [3:0]  clint_arid,
   output logic [7:0]  clint_arlen,
   output logic [2:0]  clint_arsize,
   output logic [1:0]  clint_arburst,
   input  logic        clint_rvalid,
   output logic        clint_rready,
   input  logic [31:0] clint_rdata,
   input  logic [1:0]  clint_rresp,
   input  logic        clint_rlast,
   input  logic [3:0]  clint_rid,

   output logic        soc_arvalid,
   input  logic        soc_arready,
   output logic [31:0] soc_araddr,
   output logic [3:0]  soc_arid,
   output logic [7:0]  soc_arlen,
   output logic [2:0]  soc_arsize,
   output logic [1:0]  soc_arburst,
   input  logic        soc_rvalid,
   output logic        soc_rready,
   input  logic [31:0] soc_rdata,
   input  logic [1:0]  soc_rresp,
   input  logic        soc_rlast,
   input  logic [3:0]  soc_rid
);

   state_e  state_q, state_d;
   ar_req_t ar_q, ar_d;
   logic    sel_q, sel_d;
   logic    hit;

   ysyx_25020037_rxbar_dec u_dec (
      .addr      (in_araddr),
      .sel_clint (hit)
   );

   logic act, ar_act, r_act;
   assign act    = ~rst;
   assign ar_act = act & (state_q == S_ADDR);
   assign r_act  = act & (state_q == S_DATA);

   assign in_arready = act & (state_q == S_IDLE);

   always_comb begin
      state_d = state_q;
      ar_d    = ar_q;
      sel_d   = sel_q;
      case (state_q)
         S_IDLE: if (in_arvalid) begin
            ar_d    = '{addr: in_araddr, id: in_arid, len: in_arlen,
                        size: in_arsize, burst: in_arburst};
            sel_d   = hit;
            state_d = S_ADDR;
         end
         S_ADDR: if (sel_q ? clint_arready : soc_arready) state_d = S_DATA;
         S_DATA: if (in_rvalid & in_rready & in_rlast) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ar_q    <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ar_q    <= ar_d;
         sel_q   <= sel_d;
      end
   end

   // Both ports see the latched payload; only arvalid distinguishes them.
   assign clint_arvalid = ar_act & sel_q;
   assign soc_arvalid   = ar_act & ~sel_q;
   assign clint_araddr  = ar_q.addr;
   assign clint_arid    = ar_q.id;
   assign clint_arlen   = ar_q.len;
   assign clint_arsize  = ar_q.size;
   assign clint_arburst = ar_q.burst;
   assign soc_araddr    = ar_q.addr;
   assign soc_arid      = ar_q.id;
   assign soc_arlen     = ar_q.len;
   assign soc_arsize    = ar_q.size;
   assign soc_arburst   = ar_q.burst;

   assign clint_rready = r_act & sel_q & in_rready;
   assign soc_rready   = r_act & ~sel_q & in_rready;

   always_comb begin
      in_rvalid = 1'b0;
      in_rdata  = '0;
      in_rresp  = '0;
      in_rlast  = 1'b0;
      in_rid    = '0;
      if (r_act) begin
         if (sel_q) begin
            in_rvalid = clint_rvalid;
            in_rdata  = clint_rdata;
            in_rresp  = clint_rresp;
            in_rlast  = clint_rlast;
            in_rid    = clint_rid;
         end else begin
            in_rvalid = soc_rvalid;
            in_rdata  = soc_rdata;
            in_rresp  = soc_rresp;
            in_rlast  = soc_rlast;
            in_rid    = soc_rid;
         end
      end
   end

endmodule
